// File: rtl/fp_cmp_sched_pkg.sv
// Shared FP compare scheduler definitions: FSM encoding, default timing and
// IEEE-754 single-precision special values.
package fp_cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int LAT_DEFAULT = 2;
  localparam int TMO_DEFAULT = 15;

  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_cmp_sched_rr_arb.sv
// Round-robin arbiter: grants the lowest requesting index at or after rr_ptr,
// wrapping around; purely combinational.
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(NREQ);

  always_comb begin
    int   j;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fp_cmp_sched.sv
// Schedules compare requests from NREQ requesters onto one shared registered
// FP comparator, with a bounded wait and a held response handshake.
module fp_cmp_sched
  import fp_cmp_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int LAT  = LAT_DEFAULT,
  parameter int TMO  = TMO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [W-1:0]            cmp_in1,
  output logic [W-1:0]            cmp_in2,
  output logic                    cmp_act,
  input  logic                    cmp_eq,
  input  logic                    cmp_great,
  input  logic                    cmp_less,
  input  logic                    cmp_inv,
  input  logic                    cmp_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_eq,
  output logic                    rsp_great,
  output logic                    rsp_less,
  output logic                    rsp_inv,
  output logic                    rsp_tmo
);

  localparam int            IW      = $clog2(NREQ);
  localparam int            CW      = $clog2(TMO + 1);
  localparam logic [CW-1:0] LAT_C   = CW'(LAT);
  localparam logic [CW-1:0] TMO_C   = CW'(TMO);
  localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   id;
  logic [IW-1:0]   gnt_idx;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [W-1:0]    gnt_a;
  logic [W-1:0]    gnt_b;
  logic            capture;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any = |gnt;

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_a = req_a[i*W +: W];
        gnt_b = req_b[i*W +: W];
      end
    end
  end

  // The accept strobe must coincide with the grant cycle, so it is decoded
  // from state; gating with rst keeps it quiet while reset is held.
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;

  // Early done pulses belong to a previous operation and are ignored.
  assign capture = (cnt >= LAT_C) && cmp_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      id        <= '0;
      cmp_in1   <= '0;
      cmp_in2   <= '0;
      cmp_act   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_eq    <= 1'b0;
      rsp_great <= 1'b0;
      rsp_less  <= 1'b0;
      rsp_inv   <= 1'b0;
      rsp_tmo   <= 1'b0;
    end else begin
      cmp_act <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            id      <= gnt_idx;
            cmp_in1 <= gnt_a;
            cmp_in2 <= gnt_b;
            cmp_act <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CW'(1);
          state <= WAIT;
        end
        WAIT: begin
          // A timeout reports an invalid compare with no ordering flags.
          if (capture || cnt == TMO_C) begin
            rsp_eq    <= capture & cmp_eq;
            rsp_great <= capture & cmp_great;
            rsp_less  <= capture & cmp_less;
            rsp_inv   <= ~capture | cmp_inv;
            rsp_tmo   <= ~capture;
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            cnt       <= '0;
            cmp_in1   <= '0;
            cmp_in2   <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_eq    <= 1'b0;
            rsp_great <= 1'b0;
            rsp_less  <= 1'b0;
            rsp_inv   <= 1'b0;
            rsp_tmo   <= 1'b0;
            rr_ptr    <= (id == LAST_ID) ? '0 : id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
